mel_filter_bank: RTL and testbench

- Applies a 64-band triangular mel filterbank to a streamed power spectrum: 513 FFT bins per frame (n_fft = 1024, sr = 16 kHz).
- Accepts one bin per cycle and accumulates weighted contributions into 64 band accumulators.
- On the last bin of a frame, emits all 64 saturated band energies in parallel on one bus.
- Sits between the power-spectrum stage and the log stage of the log-mel pipeline.

---
 rtl/mel_filter_bank.sv | 161 ++++++++++++++++
 tb/tb_mel_filter_bank.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mel_filter_bank.sv
// 64-band triangular mel filterbank over a streamed 513-bin power spectrum.
// Coefficients are built at elaboration; one accumulate stage, parallel registered output.
module mel_filter_bank #(
    parameter int I_BW = 14,
    parameter int O_BW = 14
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [9:0]          in_group_idx,
    input  logic [I_BW-1:0]     data_i,
    input  logic [6:0]          in_group_num,
    input  logic                di_en,
    input  logic                is_first_in,
    input  logic                is_last_in,
    output logic [O_BW*64-1:0]  data_o,
    output logic                do_en,
    output logic [6:0]          out_group_num
);
    localparam int NB   = 64;
    localparam int NBIN = 513;
    localparam int AW   = 32;
    localparam logic signed [AW-1:0] OMAX = AW'(2 ** (O_BW - 1) - 1);
    localparam logic signed [AW-1:0] OMIN = AW'(-(2 ** (O_BW - 1)));
    localparam logic signed [AW-1:0] ZERO = '0;

    // HTK mel point i in Hz; the top edge is pinned to fmax so bin 512 lands exactly on it.
    function automatic real mel_pt(input int i);
        real mel_max;
        mel_max = 2595.0 * $log10(1.0 + 8000.0 / 700.0);
        if (i >= 65) begin
            return 8000.0;
        end else begin
            return 700.0 * (10.0 ** (mel_max * real'(i) / 65.0 / 2595.0) - 1.0);
        end
    endfunction

    function automatic logic [15:0] rom_entry(input int k);
        real        freq;
        real        lo;
        real        hi;
        int         wi;
        logic [6:0] f;
        logic [8:0] w;
        freq = real'(k) * 15.625;
        f    = 7'd64;
        w    = 9'd0;
        for (int j = 0; j < 65; j++) begin
            lo = mel_pt(j);
            hi = mel_pt(j + 1);
            if (freq >= lo && freq < hi) begin
                wi = $rtoi(256.0 * (freq - lo) / (hi - lo) + 0.5);
                f  = j[6:0];
                w  = wi[8:0];
            end
        end
        return {f, w};
    endfunction

    function automatic logic [O_BW-1:0] sat_band(input logic signed [AW-1:0] a);
        logic signed [AW-1:0] s;
        s = a >>> 8;
        if (s > OMAX) begin
            return OMAX[O_BW-1:0];
        end else if (s < OMIN) begin
            return OMIN[O_BW-1:0];
        end else begin
            return s[O_BW-1:0];
        end
    endfunction

    logic [15:0] rom_s [NBIN];

    for (genvar k = 0; k < NBIN; k++) begin : g_rom
        localparam logic [15:0] ENTRY = rom_entry(k);
        assign rom_s[k] = ENTRY;
    end

    logic                 hit_s;
    logic [6:0]           f_s;
    logic [8:0]           w_s;
    logic signed [AW-1:0] d_ext_s;
    logic signed [AW-1:0] up_s;
    logic signed [AW-1:0] dn_s;

    logic signed [AW-1:0] acc_q [NB];
    logic signed [AW-1:0] acc_d [NB];
    logic [O_BW*NB-1:0]   data_q;
    logic [O_BW*NB-1:0]   data_d;
    logic [6:0]           grp_q;
    logic [6:0]           grp_d;
    logic                 do_en_q;
    logic                 do_en_d;

    // ROM lookup and the rising/falling products of the current bin
    always_comb begin
        hit_s = 1'b0;
        f_s   = 7'd0;
        w_s   = 9'd0;
        if (in_group_idx <= 10'd512) begin
            hit_s      = 1'b1;
            {f_s, w_s} = rom_s[in_group_idx];
        end else begin
            hit_s = 1'b0;
        end
        d_ext_s = {{(AW - I_BW){data_i[I_BW-1]}}, data_i};
        up_s    = d_ext_s * $signed({{(AW - 9){1'b0}}, w_s});
        dn_s    = d_ext_s * $signed({{(AW - 9){1'b0}}, 9'd256 - w_s});
    end

    // Accumulator update, and saturated output capture on the last bin
    always_comb begin
        for (int m = 0; m < NB; m++) begin
            acc_d[m] = acc_q[m];
        end
        data_d  = data_q;
        grp_d   = grp_q;
        do_en_d = 1'b0;
        if (di_en) begin
            for (int m = 0; m < NB; m++) begin
                acc_d[m] = (is_first_in ? ZERO : acc_q[m])
                         + ((hit_s && (f_s == 7'(m)))     ? up_s : ZERO)
                         + ((hit_s && (f_s == 7'(m + 1))) ? dn_s : ZERO);
            end
            if (is_last_in) begin
                for (int m = 0; m < NB; m++) begin
                    data_d[O_BW*m +: O_BW] = sat_band(acc_d[m]);
                end
                grp_d   = in_group_num;
                do_en_d = 1'b1;
            end else begin
                do_en_d = 1'b0;
            end
        end else begin
            do_en_d = 1'b0;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int m = 0; m < NB; m++) begin
                acc_q[m] <= '0;
            end
            data_q  <= '0;
            grp_q   <= 7'd0;
            do_en_q <= 1'b0;
        end else begin
            for (int m = 0; m < NB; m++) begin
                acc_q[m] <= acc_d[m];
            end
            data_q  <= data_d;
            grp_q   <= grp_d;
            do_en_q <= do_en_d;
        end
    end

    assign data_o        = data_q;
    assign do_en         = do_en_q;
    assign out_group_num = grp_q;

endmodule

// File: tb/tb_mel_filter_bank.sv
// Scoreboard bench for mel_filter_bank: a filterbank-matrix reference model predicts
// each frame's bands; a monitor checks every do_en pulse against the queued prediction.
module tb_mel_filter_bank;
    localparam int I_BW = 14;
    localparam int O_BW = 14;
    localparam int NB   = 64;
    localparam int NBIN = 513;

    logic                clk = 1'b0;
    logic                rst;
    logic [9:0]          in_group_idx;
    logic [I_BW-1:0]     data_i;
    logic [6:0]          in_group_num;
    logic                di_en;
    logic                is_first_in;
    logic                is_last_in;
    logic [O_BW*NB-1:0]  data_o;
    logic                do_en;
    logic [6:0]          out_group_num;

    mel_filter_bank #(.I_BW(I_BW), .O_BW(O_BW)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_group_idx  (in_group_idx),
        .data_i        (data_i),
        .in_group_num  (in_group_num),
        .di_en         (di_en),
        .is_first_in   (is_first_in),
        .is_last_in    (is_last_in),
        .data_o        (data_o),
        .do_en         (do_en),
        .out_group_num (out_group_num)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [O_BW*NB-1:0] data;
        logic [6:0]         grp;
        int                 stamp;
    } exp_t;
    exp_t sb_q[$];

    // Filterbank weight matrix (Q0.8) and the current frame's stimulus
    int wt [NB][NBIN];
    int fdat [NBIN];
    int fidx [NBIN];

    task automatic cmp_int(input string nm, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, want);
        end
    endtask

    task automatic build_model();
        real p [66];
        real mel_max;
        real freq;
        int  w;
        bit  found;
        mel_max = 2595.0 * $log10(1.0 + 8000.0 / 700.0);
        for (int i = 0; i < 65; i++) p[i] = 700.0 * (10.0 ** (mel_max * real'(i) / 65.0 / 2595.0) - 1.0);
        p[65] = 8000.0;
        for (int m = 0; m < NB; m++)
            for (int k = 0; k < NBIN; k++) wt[m][k] = 0;
        for (int k = 0; k < NBIN; k++) begin
            freq  = real'(k) * 15.625;
            found = 1'b0;
            for (int j = 0; j < 65; j++) begin
                if (freq >= p[j] && freq < p[j+1]) begin
                    found = 1'b1;
                    w = $rtoi(256.0 * (freq - p[j]) / (p[j+1] - p[j]) + 0.5);
                    if (j <= 63) wt[j][k] = w;         // rising edge of band j
                    if (j >= 1)  wt[j-1][k] = 256 - w; // falling edge of band j-1
                end
            end
            if (!found) wt[63][k] = 256;
        end
    endtask

    function automatic exp_t model_frame(input int nb, input int grp);
        exp_t   e;
        longint acc;
        longint q;
        e.data = '0;
        for (int m = 0; m < NB; m++) begin
            acc = 0;
            for (int b = 0; b < nb; b++)
                if (fidx[b] >= 0 && fidx[b] <= 512) acc += longint'(fdat[b]) * longint'(wt[m][fidx[b]]);
            q = (acc >= 0) ? acc / 256 : -((-acc + 255) / 256);
            if (q > 8191) q = 8191;
            if (q < -8192) q = -8192;
            e.data[O_BW*m +: O_BW] = q[O_BW-1:0];
        end
        e.grp   = grp[6:0];
        e.stamp = 0;
        return e;
    endfunction

    function automatic int band(input int m);
        return int'($signed(data_o[O_BW*m +: O_BW]));
    endfunction

    // Monitor: every do_en pulse must match the oldest prediction, one cycle after its last bin
    always @(negedge clk) begin
        exp_t e;
        int   nbad_b;
        int   first_b;
        if (do_en) begin
            if (sb_q.size() == 0) begin
                cmp_int("unexpected_do_en", 1, 0);
            end else begin
                e = sb_q.pop_front();
                nbad_b  = 0;
                first_b = -1;
                for (int m = 0; m < NB; m++) begin
                    if (data_o[O_BW*m +: O_BW] != e.data[O_BW*m +: O_BW]) begin
                        nbad_b++;
                        if (first_b < 0) first_b = m;
                    end
                end
                n_cmp++;
                if (nbad_b != 0) begin
                    n_bad++;
                    $display("FAIL bands (grp %0d): %0d bands differ, band %0d got %0d, expected %0d",
                             e.grp, nbad_b, first_b, band(first_b),
                             int'($signed(e.data[O_BW*first_b +: O_BW])));
                end
                cmp_int("out_group_num", int'(out_group_num), int'(e.grp));
                cmp_int("latency_cycle", cyc, e.stamp);
            end
        end
    end

    task automatic drive_frame(input int nb, input int grp, input int gap_at, input int gap_len,
                               input int rst_at);
        exp_t e;
        for (int b = 0; b < nb; b++) begin
            if (b == gap_at) begin
                for (int g = 0; g < gap_len; g++) begin
                    di_en        = 1'b0;
                    in_group_idx = 10'($urandom_range(1023));
                    data_i       = 14'($urandom);
                    is_first_in  = 1'($urandom_range(1));
                    is_last_in   = 1'($urandom_range(1));
                    in_group_num = 7'($urandom_range(127));
                    @(posedge clk); #1;
                end
            end
            if (b == rst_at) begin
                di_en = 1'b0;
                rst   = 1'b0;
                repeat (3) begin @(posedge clk); #1; end
                rst = 1'b1;
                return;
            end
            di_en        = 1'b1;
            in_group_idx = fidx[b][9:0];
            data_i       = fdat[b][I_BW-1:0];
            is_first_in  = (b == 0);
            is_last_in   = (b == nb - 1);
            in_group_num = grp[6:0];
            if (b == nb - 1) begin
                e       = model_frame(nb, grp);
                e.stamp = cyc + 1;
                sb_q.push_back(e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic fill_const(input int v);
        for (int b = 0; b < NBIN; b++) begin fidx[b] = b; fdat[b] = v; end
    endtask

    task automatic fill_rand();
        for (int b = 0; b < NBIN; b++) begin fidx[b] = b; fdat[b] = int'($urandom_range(16383)) - 8192; end
    endtask

    task automatic idle(input int n);
        di_en = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        int sum;
        int nz;
        int saved [NBIN];
        build_model();
        rst = 1'b0; di_en = 1'b0; in_group_idx = 10'd0; data_i = '0;
        in_group_num = 7'd0; is_first_in = 1'b0; is_last_in = 1'b0;

        // Reset held with activity on the inputs
        for (int i = 0; i < 8; i++) begin
            di_en = i[0]; is_first_in = 1'b1; is_last_in = 1'b1;
            data_i = 14'($urandom); in_group_num = 7'($urandom_range(88));
            @(negedge clk);
            cmp_int("rst_data_o_zero", (data_o == '0) ? 0 : 1, 0);
            cmp_int("rst_do_en", int'(do_en), 0);
            cmp_int("rst_out_group_num", int'(out_group_num), 0);
        end
        @(posedge clk); #1;
        di_en = 1'b0;
        rst   = 1'b1;
        idle(2);

        fill_const(0);
        drive_frame(NBIN, 3, -1, 0, -1);
        idle(2);

        fill_const(1000);
        for (int fr = 0; fr < 64; fr++) drive_frame(NBIN, fr, -1, 0, -1);
        di_en = 1'b0;
        @(negedge clk);
        cmp_int("sat_band63", band(63), 8191);
        cmp_int("sat_band50", band(50), 8191);
        idle(2);

        fill_const(0);
        fdat[100] = 256;
        drive_frame(NBIN, 7, -1, 0, -1);
        di_en = 1'b0;
        @(negedge clk);
        sum = 0; nz = 0;
        for (int m = 0; m < NB; m++) begin sum += band(m); if (band(m) != 0) nz++; end
        cmp_int("impulse_sum", sum, 256);
        cmp_int("impulse_nonzero_bands", nz, 2);
        idle(2);

        fill_const(-8192);
        drive_frame(NBIN, 9, -1, 0, -1);
        di_en = 1'b0;
        @(negedge clk);
        cmp_int("negsat_band63", band(63), -8192);
        idle(2);

        fill_rand();
        for (int b = 0; b < NBIN; b++) saved[b] = fdat[b];
        drive_frame(NBIN, 20, -1, 0, -1);
        for (int b = 0; b < NBIN; b++) fdat[b] = saved[b];
        drive_frame(NBIN, 21, 300, 50, -1);
        idle(2);

        fill_rand();
        drive_frame(NBIN, 30, -1, 0, 200);
        idle(4);
        fill_rand();
        drive_frame(NBIN, 31, -1, 0, -1);

        for (int fr = 0; fr < 3; fr++) begin
            fill_rand();
            drive_frame(NBIN, 40 + fr, -1, 0, -1);
        end

        fill_rand();
        for (int b = 0; b < NBIN; b++) fidx[b] = int'($urandom_range(1023));
        drive_frame(NBIN, 50, -1, 0, -1);

        fidx[0] = int'($urandom_range(512));
        fdat[0] = int'($urandom_range(16383)) - 8192;
        drive_frame(1, 88, -1, 0, -1);
        fidx[0] = 512;
        fdat[0] = 8191;
        drive_frame(1, 87, -1, 0, -1);

        idle(5);
        cmp_int("scoreboard_drained", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
